// File: rtl/amo_sequencer.sv
// Sequencer for RISC-V LR / SC / AMO operations against a single-port memory,
// with one address reservation that snoops and atomic writes can break.
// Optional macro AMO_RESV_TIMEOUT_EN adds a reservation expiry counter.
// Ports: clk/reset (sync, active-high); start/op/funct5/addr/rs2_data request;
//        mem_req/mem_we/mem_addr/mem_wdata -> memory, mem_rdata/mem_ack <- memory;
//        snoop_we/snoop_addr external store notification; busy/done/err/rd_data result.
module amo_sequencer #(
  parameter int XLEN         = 64,
  parameter int RESV_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [4:0]      funct5,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] rs2_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  input  logic            snoop_we,
  input  logic [XLEN-1:0] snoop_addr,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_RESP} state_t;

  localparam logic [1:0] OP_LR  = 2'b00;
  localparam logic [1:0] OP_SC  = 2'b01;
  localparam logic [1:0] OP_AMO = 2'b10;

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  // A non-positive timeout has no meaning; this block only exists so the
  // parameter stays referenced when the expiry counter is compiled out.
  if (RESV_TIMEOUT <= 0) begin : g_bad_resv_timeout
  end

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      funct5_q, funct5_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            err_q, err_d;
  logic            resv_vld_q, resv_vld_d;
  logic [XLEN-1:0] resv_addr_q, resv_addr_d;

  logic resv_set;    // LR read completed this cycle
  logic resv_clr;    // SC finished or AMO stored to the reserved address
  logic tmo_expire;  // reservation lifetime ran out

  function automatic logic f5_supported(input logic [4:0] f);
    case (f)
      F5_ADD, F5_SWAP, F5_XOR, F5_OR, F5_AND,
      F5_MIN, F5_MAX, F5_MINU, F5_MAXU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] amo_alu(input logic [4:0] f,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (f)
      F5_SWAP: return b;
      F5_ADD:  return a + b;
      F5_XOR:  return a ^ b;
      F5_AND:  return a & b;
      F5_OR:   return a | b;
      F5_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      F5_MAX:  return ($signed(a) > $signed(b)) ? a : b;
      F5_MINU: return (a < b) ? a : b;
      F5_MAXU: return (a > b) ? a : b;
      default: return a;
    endcase
  endfunction

  // Sequencer next-state and datapath captures.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct5_d  = funct5_q;
    addr_d    = addr_q;
    rs2_d     = rs2_q;
    old_d     = old_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    resv_set  = 1'b0;
    resv_clr  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          funct5_d = funct5;
          addr_d   = addr;
          rs2_d    = rs2_data;
          err_d    = 1'b0;
          if ((addr[2:0] != 3'b000) || (op == 2'b11) ||
              ((op == OP_AMO) && !f5_supported(funct5))) begin
            state_d   = S_RESP;
            err_d     = 1'b1;
            rd_data_d = '0;
            resv_clr  = (op == OP_SC);
          end else if (op == OP_SC) begin
            if (resv_vld_q && (resv_addr_q == addr)) begin
              state_d = S_WRITE;
              wdata_d = rs2_data;
            end else begin
              state_d   = S_RESP;
              rd_data_d = XLEN'(1);
              resv_clr  = 1'b1;
            end
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (mem_ack) begin
          if (op_q == OP_LR) begin
            state_d   = S_RESP;
            rd_data_d = mem_rdata;
            resv_set  = 1'b1;
          end else begin
            state_d = S_CALC;
            old_d   = mem_rdata;
          end
        end
      end
      S_CALC: begin
        wdata_d = amo_alu(funct5_q, old_q, rs2_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (mem_ack) begin
          state_d = S_RESP;
          if (op_q == OP_SC) begin
            rd_data_d = '0;
            resv_clr  = 1'b1;
          end else begin
            rd_data_d = old_q;
            resv_clr  = (addr_q == resv_addr_q);
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AMO_RESV_TIMEOUT_EN
  localparam int TW = $clog2(RESV_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts down while a reservation is live; expiry is raised on the cycle
  // the count would reach zero, so the reservation survives RESV_TIMEOUT cycles.
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_expire = 1'b0;
    if (resv_set) begin
      tmo_cnt_d = TW'(RESV_TIMEOUT);
    end else if (resv_vld_q) begin
      if (tmo_cnt_q <= TW'(1)) begin
        tmo_expire = 1'b1;
        tmo_cnt_d  = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_expire = 1'b0;
`endif

  // Reservation tracking. A snoop to the LR address in the same cycle as the
  // LR completes prevents the reservation from being set at all.
  always_comb begin
    resv_vld_d  = resv_vld_q;
    resv_addr_d = resv_addr_q;
    if ((snoop_we && (snoop_addr == resv_addr_q)) || resv_clr || tmo_expire) begin
      resv_vld_d = 1'b0;
    end
    if (resv_set) begin
      if (snoop_we && (snoop_addr == addr_q)) begin
        resv_vld_d = 1'b0;
      end else begin
        resv_vld_d  = 1'b1;
        resv_addr_d = addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      funct5_q    <= '0;
      addr_q      <= '0;
      rs2_q       <= '0;
      old_q       <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
      resv_vld_q  <= 1'b0;
      resv_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      funct5_q    <= funct5_d;
      addr_q      <= addr_d;
      rs2_q       <= rs2_d;
      old_q       <= old_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
      resv_vld_q  <= resv_vld_d;
      resv_addr_q <= resv_addr_d;
    end
  end

  // Address and data come straight from captured registers, so they hold
  // steady for the whole memory handshake.
  assign mem_req   = (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RESP);
  assign err       = err_q;
  assign rd_data   = rd_data_q;

endmodule

// File: doc/amo_sequencer.md
AMO_SEQUENCER -- requirements
Module: amo_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/address width in bits.
REQ-002 SHALL have parameter RESV_TIMEOUT, default 64, cycles before an LR reservation expires.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin an atomic operation; sampled only in IDLE.
REQ-006 SHALL have port op  input  2  00 LR, 01 SC, 10 AMO, 11 reserved.
REQ-007 SHALL have port funct5  input  5  AMO selector, RISC-V A-extension encoding.
REQ-008 SHALL have port addr  input  XLEN  target address, captured with start.
REQ-009 SHALL have port rs2_data  input  XLEN  SC store data / AMO operand, captured with start.
REQ-010 SHALL have port mem_req, mem_we  output  1 each  memory request and write-enable.
REQ-011 SHALL have port mem_addr, mem_wdata  output  XLEN each  memory address and write data.
REQ-012 SHALL have port mem_rdata  input  XLEN; mem_ack  input  1  read data, valid with ack.
REQ-013 SHALL have port snoop_we  input  1; snoop_addr  input  XLEN  external store notification.
REQ-014 SHALL have port busy, done, err  output  1 each; rd_data  output  XLEN  result to register file.

Function
REQ-015 SHALL implement FSM states IDLE, READ, CALC, WRITE, RESP.
REQ-016 IDLE with start: op=LR or AMO -> READ; op=SC with valid matching reservation -> WRITE; SC without it -> RESP with rd_data=1.
REQ-017 Misaligned addr (addr[2:0]!=0), op=11, or unsupported funct5 for AMO SHALL go IDLE -> RESP with err=1, rd_data=0, no memory access.
REQ-018 READ/WRITE SHALL hold mem_req=1 with stable mem_addr/mem_we/mem_wdata until the cycle mem_ack=1; the state advances on that edge.
REQ-019 READ on ack: LR -> RESP with rd_data=mem_rdata, reservation set to addr; AMO -> CALC with old value latched.
REQ-020 CALC SHALL take exactly one cycle, computing new = f(old, rs2_data) for SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU; ADD wraps modulo 2^XLEN; MIN/MAX signed, MINU/MAXU unsigned.
REQ-021 WRITE on ack -> RESP; rd_data = old value for AMO, 0 for successful SC.
REQ-022 RESP SHALL assert done=1 for exactly one cycle, then return to IDLE; rd_data and err held until next start.
REQ-023 busy SHALL be 1 in every state except IDLE; start while busy is ignored.
REQ-024 Minimum latency start-to-done: LR 3 cycles with zero-wait ack, AMO 5, successful SC 3, failed SC 2.
REQ-025 Reservation SHALL be cleared by: any SC (pass or fail) reaching RESP; AMO write to the reserved address; snoop_we with snoop_addr equal to the reservation address.
REQ-026 snoop clear in the same cycle as LR read ack: clear wins, reservation not set.
REQ-027 A snoop clearing the reservation while SC is in WRITE SHALL NOT abort the in-flight store.

Reset
REQ-028 reset SHALL force IDLE, clear reservation and timeout counter; mem_req, mem_we, busy, done, err = 0; mem_addr, mem_wdata, rd_data = 0.
REQ-029 reset mid-operation SHALL drop mem_req the following cycle with no done pulse.

Configuration
REQ-030 Macro AMO_RESV_TIMEOUT_EN defined: a counter starts at LR success and clears the reservation after RESV_TIMEOUT cycles; reloaded on each new LR.
REQ-031 AMO_RESV_TIMEOUT_EN undefined: no counter logic; the reservation persists until cleared per REQ-025.

Verification
REQ-032 LR 0x100 (mem=0x5), then SC 0x100 data 0x9 -> LR rd_data=0x5; SC writes 0x9, rd_data=0.
REQ-033 LR 0x100, snoop_we at 0x100, SC 0x100 -> SC rd_data=1, mem_req never asserted for SC.
REQ-034 AMOADD 0x200 (mem=0xFFFF_FFFF_FFFF_FFFF, rs2=2) -> write 0x1, rd_data=0xFFFF_FFFF_FFFF_FFFF; AMOMIN (mem=-1, rs2=1) -> write -1.
REQ-035 mem_ack delayed 4 cycles on READ -> mem_req/mem_addr stable throughout; done 4 cycles later than zero-wait.
REQ-036 AMO to 0x104 -> err=1, done after 2 cycles, no mem_req; reset asserted during WRITE -> IDLE, no done.
REQ-037 With AMO_RESV_TIMEOUT_EN, RESV_TIMEOUT=8: LR, wait 10 cycles, SC -> rd_data=1.
